// File: rtl/debug_sequencer_pkg.sv
// rtl/debug_sequencer_pkg.sv - opcode, data-select and FSM state encodings for debug_sequencer
package debug_sequencer_pkg;

  // DEBUG_OP[3:1]
  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_MEM_RD = 3'd1,
    OP_MEM_WR = 3'd2,
    OP_REG_RD = 3'd3,
    OP_REG_WR = 3'd4,
    OP_CC_RD  = 3'd5,
    OP_PC_RD  = 3'd6,
    OP_PC_WR  = 3'd7
  } dbg_op_e;

  // DEBUG_DATAX read-data source
  typedef enum logic [1:0] {
    DX_DIN       = 2'd0,
    DX_REGB_DATA = 2'd1,
    DX_CC_DATA   = 2'd2,
    DX_PC_A_NEXT = 2'd3
  } datax_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_INC     = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_e;

  // Writes and NOP leave the select at DIN; it is a don't-care for them.
  function automatic datax_e datax_for(input dbg_op_e op);
    datax_e sel;
    sel = DX_DIN;
    case (op)
      OP_REG_RD: sel = DX_REGB_DATA;
      OP_CC_RD:  sel = DX_CC_DATA;
      OP_PC_RD:  sel = DX_PC_A_NEXT;
      default:   sel = DX_DIN;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/debug_sequencer_if.sv
// rtl/debug_sequencer_if.sv - debug port <-> sequencer handshake bundle
// master (debug port): drives req, op, mode, stop; receives ack, addr_inc_en, ld_data_en, datax
// slave (sequencer):   the reverse
interface debug_sequencer_if;
  logic       req;
  logic [3:0] op;
  logic       mode;
  logic       stop;
  logic       ack;
  logic       addr_inc_en;
  logic       ld_data_en;
  logic [1:0] datax;

  modport master (output req, op, mode, stop, input ack, addr_inc_en, ld_data_en, datax);
  modport slave  (input req, op, mode, stop, output ack, addr_inc_en, ld_data_en, datax);
endinterface

// File: rtl/debug_wait_timer.sv
// rtl/debug_wait_timer.sv - bus wait-state counter with expiry flag
// Ports: clk, resetn (async active-low), clr (zero the count), en (count this cycle),
//        expired (count has reached LIMIT-1, i.e. this is the LIMIT-th enabled cycle)
module debug_wait_timer #(
  parameter int LIMIT = 64,
  parameter int TW    = 7
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + TW'(1);
    end
  end

  assign expired = (count == TW'(LIMIT - 1));

endmodule

// File: rtl/debug_sequencer.sv
// rtl/debug_sequencer.sv - executes one debug operation per REQ/ACK handshake
// Optional: DEBUG_SEQ_TIMEOUT_EN adds a bus wait-state timeout that sets debug_err.
// Ports: clk, resetn (async active-low); dbg (debug port, slave side);
//        cpu_halted, bus_ready (CPU side inputs);
//        dbg_halt_req, dbg_bus_rd, dbg_bus_wr, dbg_reg_wr, dbg_pc_ld (CPU strobes);
//        debug_busy, debug_err (status). All outputs are registers.
module debug_sequencer
  import debug_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TW             = 7
) (
  input  logic             clk,
  input  logic             resetn,
  debug_sequencer_if.slave dbg,
  input  logic             cpu_halted,
  input  logic             bus_ready,
  output logic             dbg_halt_req,
  output logic             dbg_bus_rd,
  output logic             dbg_bus_wr,
  output logic             dbg_reg_wr,
  output logic             dbg_pc_ld,
  output logic             debug_busy,
  output logic             debug_err
);

  if ((2 ** TW) <= TIMEOUT_CYCLES) begin : g_tw_check
    $error("debug_sequencer: TW too narrow for TIMEOUT_CYCLES");
  end

  seq_state_e state, next_state;
  dbg_op_e    op_q;
  logic       incx_q;
  datax_e     datax_q;
  logic       start;

  logic ack_q, inc_q, ld_q, halt_q, rd_q, wr_q, reg_wr_q, pc_ld_q, busy_q;
  logic rd_d, wr_d;

`ifdef DEBUG_SEQ_TIMEOUT_EN
  logic timer_expired;
  logic err_q;

  // Clearing throughout EXEC guarantees a zero count on the first WAIT cycle.
  debug_wait_timer #(.LIMIT(TIMEOUT_CYCLES), .TW(TW)) u_wait_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (state == ST_EXEC),
    .en      (state == ST_WAIT),
    .expired (timer_expired)
  );

  // bus_ready wins over expiry on the same cycle: the access did complete.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (state == ST_WAIT && !bus_ready && timer_expired) begin
      err_q <= 1'b1;
    end else if (state == ST_EXEC && op_q == OP_NOP && incx_q) begin
      err_q <= 1'b0;
    end
  end

  assign debug_err = err_q;
`else
  assign debug_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dbg.req && dbg.mode && cpu_halted) begin
          next_state = ST_EXEC;
          start      = 1'b1;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_MEM_RD, OP_MEM_WR: next_state = ST_WAIT;
          OP_REG_WR, OP_PC_WR:  next_state = ST_INC;
          OP_NOP:               next_state = ST_DONE;
          default:              next_state = ST_CAPTURE;
        endcase
      end
      ST_WAIT: begin
        if (bus_ready) begin
          next_state = (op_q == OP_MEM_RD) ? ST_CAPTURE : ST_INC;
        end
`ifdef DEBUG_SEQ_TIMEOUT_EN
        else if (timer_expired) begin
          next_state = ST_DONE;
        end
`endif
      end
      ST_CAPTURE: next_state = ST_INC;
      ST_INC:     next_state = ST_DONE;
      ST_DONE:    if (!dbg.req) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Bus strobes follow next_state so they are high exactly during WAIT;
  // every other output is a registered decode of the current state.
  assign rd_d = (next_state == ST_WAIT) && (op_q == OP_MEM_RD);
  assign wr_d = (next_state == ST_WAIT) && (op_q == OP_MEM_WR);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q     <= OP_NOP;
      incx_q   <= 1'b0;
      datax_q  <= DX_DIN;
      ack_q    <= 1'b0;
      inc_q    <= 1'b0;
      ld_q     <= 1'b0;
      halt_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      reg_wr_q <= 1'b0;
      pc_ld_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (start) begin
        op_q    <= dbg_op_e'(dbg.op[3:1]);
        incx_q  <= dbg.op[0];
        datax_q <= datax_for(dbg_op_e'(dbg.op[3:1]));
      end
      halt_q   <= dbg.mode & dbg.stop;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      reg_wr_q <= (state == ST_EXEC) && (op_q == OP_REG_WR);
      pc_ld_q  <= (state == ST_EXEC) && (op_q == OP_PC_WR);
      ld_q     <= (state == ST_CAPTURE);
      inc_q    <= (state == ST_INC) && incx_q;
      ack_q    <= (state == ST_DONE);
      busy_q   <= (state == ST_EXEC) || (state == ST_WAIT) ||
                  (state == ST_CAPTURE) || (state == ST_INC);
    end
  end

  assign dbg.ack         = ack_q;
  assign dbg.addr_inc_en = inc_q;
  assign dbg.ld_data_en  = ld_q;
  assign dbg.datax       = datax_q;
  assign dbg_halt_req    = halt_q;
  assign dbg_bus_rd      = rd_q;
  assign dbg_bus_wr      = wr_q;
  assign dbg_reg_wr      = reg_wr_q;
  assign dbg_pc_ld       = pc_ld_q;
  assign debug_busy      = busy_q;

endmodule

// File: tb/tb_debug_sequencer.sv
// tb/tb_debug_sequencer.sv - randomized self-checking bench for debug_sequencer
module tb_debug_sequencer;

`ifdef DEBUG_SEQ_TIMEOUT_EN
  localparam int TMO    = 8;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 64;
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic cpu_halted, bus_ready;
  logic dbg_halt_req, dbg_bus_rd, dbg_bus_wr, dbg_reg_wr, dbg_pc_ld, debug_busy, debug_err;

  debug_sequencer_if dbg_if ();

  debug_sequencer #(.TIMEOUT_CYCLES(TMO), .TW(7)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .dbg          (dbg_if),
    .cpu_halted   (cpu_halted),
    .bus_ready    (bus_ready),
    .dbg_halt_req (dbg_halt_req),
    .dbg_bus_rd   (dbg_bus_rd),
    .dbg_bus_wr   (dbg_bus_wr),
    .dbg_reg_wr   (dbg_reg_wr),
    .dbg_pc_ld    (dbg_pc_ld),
    .debug_busy   (debug_busy),
    .debug_err    (debug_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit err_model = 1'b0;
  int n_rd, n_wr, n_regwr, n_pcld, n_ld, n_inc, n_busy;

  function automatic logic [11:0] all_outs();
    return {dbg_if.ack, dbg_if.addr_inc_en, dbg_if.ld_data_en, dbg_if.datax, dbg_halt_req,
            dbg_bus_rd, dbg_bus_wr, dbg_reg_wr, dbg_pc_ld, debug_busy, debug_err};
  endfunction

  function automatic bit is_read(input int op3);
    return (op3 == 1) || (op3 == 3) || (op3 == 5) || (op3 == 6);
  endfunction

  function automatic int datax_of(input int op3);
    case (op3)
      3: return 1;
      5: return 2;
      6: return 3;
      default: return 0;
    endcase
  endfunction

  // Counts output activity this cycle and plays a memory that needs w wait states.
  task automatic tally(input int w);
    if (dbg_bus_rd) n_rd++;
    if (dbg_bus_wr) n_wr++;
    if (dbg_reg_wr) n_regwr++;
    if (dbg_pc_ld) n_pcld++;
    if (dbg_if.ld_data_en) n_ld++;
    if (dbg_if.addr_inc_en) n_inc++;
    if (debug_busy) n_busy++;
    bus_ready = (dbg_bus_rd || dbg_bus_wr) && ((n_rd + n_wr - 1) >= w);
  endtask

  task automatic run_txn(input int op, input int w, input bit scramble, input bit early, input string tag);
    int op3, cyc, lat, hold, hold_bad, dx_bad;
    int e_strobe, e_lat;
    bit incx, mem, tmo, a1, a2;
    op3  = (op >> 1) & 7;
    incx = (op & 1) != 0;
    mem  = (op3 == 1) || (op3 == 2);
    tmo  = mem && TMO_EN && (w >= TMO);
    e_strobe = mem ? (tmo ? TMO : w + 1) : 0;
    e_lat = tmo ? TMO + 2
                : 1 + (mem ? w + 1 : 0) + (is_read(op3) ? 1 : 0) + ((op3 != 0) ? 1 : 0) + 1;
    if (TMO_EN) begin
      if (tmo) err_model = 1'b1;
      else if (op3 == 0 && incx) err_model = 1'b0;
    end
    n_rd = 0; n_wr = 0; n_regwr = 0; n_pcld = 0; n_ld = 0; n_inc = 0; n_busy = 0;
    dx_bad = 0; lat = -1; cyc = 0;
    @(negedge clk);
    cpu_halted = 1'b1; dbg_if.mode = 1'b1; dbg_if.op = 4'(op); dbg_if.req = 1'b1; bus_ready = 1'b0;
    while (lat < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      tally(w);
      if (is_read(op3) && dbg_if.datax !== 2'(datax_of(op3))) dx_bad++;
      if (dbg_if.ack) lat = cyc - 1;
      if (early && cyc == 1) dbg_if.req = 1'b0;
      if (scramble) begin
        dbg_if.op   = 4'($urandom);
        cpu_halted  = 1'($urandom_range(0, 1));
        dbg_if.mode = 1'($urandom_range(0, 1));
      end
    end
    n_checks++;
    if (lat < 0) begin
      n_fail++;
      $display("FAIL %s ack_timeout: no ack after %0d cycles, wanted ack at %0d", tag, cyc, e_lat);
      dbg_if.req = 1'b0;
      return;
    end
    if (lat !== e_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, e_lat);
    end
    n_checks++;
    if (debug_err !== err_model) begin
      n_fail++;
      $display("FAIL %s err: got %0b want %0b", tag, debug_err, err_model);
    end
    if (early) begin
      @(negedge clk); tally(w);
      n_checks++;
      if (dbg_if.ack !== 1'b0) begin
        n_fail++;
        $display("FAIL %s single_ack: ack got %0b want 0", tag, dbg_if.ack);
      end
    end else begin
      hold = $urandom_range(0, 2); hold_bad = 0;
      repeat (hold) begin
        @(negedge clk); tally(w);
        if (dbg_if.ack !== 1'b1) hold_bad++;
      end
      dbg_if.req = 1'b0;
      @(negedge clk); tally(w); a1 = dbg_if.ack;
      @(negedge clk); tally(w); a2 = dbg_if.ack;
      n_checks++;
      if (hold_bad != 0 || {a1, a2} !== 2'b10) begin
        n_fail++;
        $display("FAIL %s ack_release: hold_bad %0d seq %0b%0b want 0 and 10", tag, hold_bad, a1, a2);
      end
    end
    n_checks++;
    if (n_rd !== ((op3 == 1) ? e_strobe : 0) || n_wr !== ((op3 == 2) ? e_strobe : 0)) begin
      n_fail++;
      $display("FAIL %s bus_strobes: rd %0d wr %0d want rd %0d wr %0d", tag, n_rd, n_wr,
               (op3 == 1) ? e_strobe : 0, (op3 == 2) ? e_strobe : 0);
    end
    n_checks++;
    if (n_regwr !== int'(op3 == 4) || n_pcld !== int'(op3 == 7)) begin
      n_fail++;
      $display("FAIL %s write_strobes: reg_wr %0d pc_ld %0d want %0d %0d", tag, n_regwr, n_pcld,
               int'(op3 == 4), int'(op3 == 7));
    end
    n_checks++;
    if (n_ld !== int'(is_read(op3) && !tmo) || n_inc !== int'(incx && op3 != 0 && !tmo)) begin
      n_fail++;
      $display("FAIL %s pulses: ld %0d inc %0d want %0d %0d", tag, n_ld, n_inc,
               int'(is_read(op3) && !tmo), int'(incx && op3 != 0 && !tmo));
    end
    n_checks++;
    if (n_busy !== e_lat - 1 || dx_bad !== 0) begin
      n_fail++;
      $display("FAIL %s busy_datax: busy %0d want %0d, datax wrong on %0d cycles want 0", tag,
               n_busy, e_lat - 1, dx_bad);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    dbg_if.req = 1'b0; dbg_if.op = 4'h0; dbg_if.mode = 1'b0; dbg_if.stop = 1'b0;
    cpu_halted = 1'b0; bus_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (all_outs() !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %03h want 000", all_outs());
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (all_outs() !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_idle: got %03h want 000", all_outs());
    end
  endtask

  task automatic test_halt_req();
    bit h0, h1, h2, h3;
    @(negedge clk);
    dbg_if.mode = 1'b1; dbg_if.stop = 1'b1;
    #1 h0 = dbg_halt_req;
    @(negedge clk); h1 = dbg_halt_req;
    dbg_if.stop = 1'b0;
    #1 h2 = dbg_halt_req;
    @(negedge clk); h3 = dbg_halt_req;
    n_checks++;
    if ({h0, h1} !== 2'b01) begin
      n_fail++;
      $display("FAIL halt_rise: got %0b%0b want 01", h0, h1);
    end
    n_checks++;
    if ({h2, h3} !== 2'b10) begin
      n_fail++;
      $display("FAIL halt_fall: got %0b%0b want 10", h2, h3);
    end
  endtask

  task automatic test_directed();
    run_txn(4'h3, 0, 1'b0, 1'b0, "mem_rd_incx");
    run_txn(4'h4, 3, 1'b0, 1'b0, "mem_wr_wait3");
    run_txn(4'h6, 0, 1'b0, 1'b0, "reg_rd");
    run_txn(4'h9, 0, 1'b0, 1'b0, "reg_wr_incx");
    run_txn(4'hF, 0, 1'b0, 1'b0, "pc_wr_incx");
    run_txn(4'hD, 0, 1'b0, 1'b1, "pc_rd_early_drop");
  endtask

  task automatic test_wait_for_halt();
    int busy_cnt;
    busy_cnt = 0;
    @(negedge clk);
    cpu_halted = 1'b0; dbg_if.mode = 1'b1; dbg_if.op = 4'hA; dbg_if.req = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if ({all_outs()[11:9], all_outs()[6:0]} !== 10'h000) busy_cnt++;
    end
    n_checks++;
    if (busy_cnt !== 0) begin
      n_fail++;
      $display("FAIL not_halted_idle: active on %0d cycles want 0", busy_cnt);
    end
    run_txn(4'hA, 0, 1'b0, 1'b0, "cc_rd_after_halt");
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    logic [11:0] during, after_cnt;
    cyc = 0; after_cnt = '0;
    @(negedge clk);
    cpu_halted = 1'b1; dbg_if.mode = 1'b1; dbg_if.op = 4'h2; dbg_if.req = 1'b1; bus_ready = 1'b0;
    while (!dbg_bus_rd && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (dbg_bus_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_op_start: bus_rd got %0b want 1", dbg_bus_rd);
    end
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1 during = all_outs();
    dbg_if.req = 1'b0;
    err_model = 1'b0;
    n_checks++;
    if (during !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_async: outputs got %03h want 000", during);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      after_cnt = after_cnt | all_outs();
    end
    n_checks++;
    if (after_cnt !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_release_idle: outputs got %03h want 000", after_cnt);
    end
    run_txn(4'h6, 0, 1'b0, 1'b0, "reg_rd_after_reset");
  endtask

  task automatic test_timeout();
`ifdef DEBUG_SEQ_TIMEOUT_EN
    run_txn(4'h2, 1000, 1'b0, 1'b0, "mem_rd_timeout");
    run_txn(4'h4, 1000, 1'b0, 1'b0, "mem_wr_timeout");
    run_txn(4'h0, 0, 1'b0, 1'b0, "nop_keeps_err");
    run_txn(4'h1, 0, 1'b0, 1'b0, "nop_clears_err");
    run_txn(4'h2, TMO - 1, 1'b0, 1'b0, "mem_rd_last_wait");
`else
    run_txn(4'h2, 80, 1'b0, 1'b0, "mem_rd_long_wait");
`endif
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      run_txn(int'($urandom_range(0, 15)), int'($urandom_range(0, 5)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_halt_req();
    test_directed();
    test_wait_for_halt();
    test_reset_mid_op();
    test_timeout();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
